// File: rtl/alu_cycle_controller.sv
// Multi-cycle control sequencer for the ALU-centred MIPS datapath.
// Stage, latched instruction fields, MUL/DIV hold counter, halt flag and retired count are registered.
module alu_cycle_controller #(
    parameter int MULDIV_CYCLES = 4,
    parameter int COUNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               ZERO,
    output logic [2:0]         stage,
    output logic [1:0]         alu_op,
    output logic               ALU_Src,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_MUL  = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd7
    } stage_t;

    stage_t           state;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [CNT_W-1:0] cnt;
    logic             is_muldiv;

    assign stage     = state;
    assign is_muldiv = (fn_q == FN_MUL) || (fn_q == FN_DIV);

    // Strobes are decoded from the current stage so they can be forced low the instant reset asserts.
    always_comb begin
        alu_op     = 2'b00;
        ALU_Src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        if (reset_n) begin
            if (state == ST_EXECUTE || state == ST_MEMORY || state == ST_WRITEBACK) begin
                case (op_q)
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_op  = 2'b11;
                        ALU_Src = 1'b1;
                    end
                    OP_BEQ, OP_BNE: alu_op = 2'b01;
                    default:        alu_op = 2'b00;
                endcase
            end
            case (state)
                ST_FETCH: ir_write = enable;
                ST_DECODE: begin
                    if (op_q == OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                ST_MEMORY: begin
                    case (op_q)
                        OP_LW: mem_read = 1'b1;
                        OP_SW: begin
                            mem_write = 1'b1;
                            pc_write  = 1'b1;
                        end
                        OP_BEQ: begin
                            pc_write = 1'b1;
                            pc_src   = ZERO ? 2'b01 : 2'b00;
                        end
                        OP_BNE: begin
                            pc_write = 1'b1;
                            pc_src   = ZERO ? 2'b00 : 2'b01;
                        end
                        default: ;
                    endcase
                end
                ST_WRITEBACK: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            op_q        <= '0;
            fn_q        <= '0;
            cnt         <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (pc_write)
                instr_count <= instr_count + COUNT_W'(1);
            case (state)
                ST_FETCH: begin
                    if (enable) begin
                        op_q  <= opcode;
                        fn_q  <= funct;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (op_q)
                        OP_J: state <= ST_FETCH;
                        OP_R: begin
                            cnt   <= is_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : '0;
                            state <= ST_EXECUTE;
                        end
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
                            cnt   <= '0;
                            state <= ST_EXECUTE;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                    endcase
                end
                ST_EXECUTE: begin
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    else if (op_q == OP_R || op_q == OP_ADDI)
                        state <= ST_WRITEBACK;
                    else
                        state <= ST_MEMORY;
                end
                ST_MEMORY:    state <= (op_q == OP_LW) ? ST_WRITEBACK : ST_FETCH;
                ST_WRITEBACK: state <= ST_FETCH;
                ST_HALT:      state <= ST_HALT;
                default:      state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cycle_controller.sv
// Scoreboard bench: the driver queues per-instruction expectations, a negedge monitor checks each retirement.
module tb_alu_cycle_controller;

    localparam int MD = 4;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        ZERO;
    logic [2:0]  stage;
    logic [1:0]  alu_op;
    logic        ALU_Src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        halted;
    logic [15:0] instr_count;

    alu_cycle_controller #(.MULDIV_CYCLES(MD), .COUNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .opcode(opcode),
        .funct(funct), .ZERO(ZERO), .stage(stage), .alu_op(alu_op),
        .ALU_Src(ALU_Src), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .halted(halted), .instr_count(instr_count)
    );

    typedef struct {
        int op;
        int lat;
        int exec;
        int aop;
        int asrc;
        int psrc;
        int rw;
        int mr;
        int mw;
        int m2r;
        int rdst;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    endtask

    // Reference model: instruction class -> observable cycle-level outcome.
    function automatic exp_t model(input int op, input int fn, input int z);
        exp_t e;
        bit md;
        e = '{op: op, lat: 4, exec: 1, aop: 0, asrc: 0, psrc: 0, rw: 0, mr: 0, mw: 0, m2r: 0, rdst: 0};
        md = (fn == 24) || (fn == 26);
        case (op)
            2:  begin e.lat = 2; e.exec = 0; e.psrc = 2; end
            0:  begin e.exec = md ? MD : 1; e.lat = 3 + e.exec; e.rw = 1; e.rdst = 1; end
            8:  begin e.aop = 3; e.asrc = 1; e.rw = 1; end
            35: begin e.lat = 5; e.aop = 3; e.asrc = 1; e.rw = 1; e.mr = 1; e.m2r = 1; end
            43: begin e.aop = 3; e.asrc = 1; e.mw = 1; end
            4:  begin e.aop = 1; e.psrc = z ? 1 : 0; end
            5:  begin e.aop = 1; e.psrc = z ? 0 : 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (stage != 3'd0 && n < 50) begin
            step();
            n++;
        end
        if (stage != 3'd0) begin
            chk("fetch_timeout", int'(stage), 0);
            finish_run();
        end
    endtask

    task automatic issue(input int op, input int fn, input int z);
        wait_fetch();
        opcode  = 6'(op);
        funct   = 6'(fn);
        ZERO    = 1'(z);
        enable  = 1'b1;
        sb.push_back(model(op, fn, z));
        step();
        // Inputs scrambled after the latch: the sequencer must ignore them until the next FETCH.
        enable  = 1'($urandom);
        opcode  = 6'($urandom);
        funct   = 6'($urandom);
    endtask

    // Monitor
    int          cyc, exec_n, aop_s, asrc_s, rw_n, mr_n, mw_n, m2r_s, rdst_s, pre_bad, hold_bad;
    bit          active = 0;
    logic [15:0] exp_count = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                active    = 0;
                exp_count = '0;
            end else begin
                if (stage == 3'd0 && ir_write) begin
                    active = 1;
                    cyc = 1; exec_n = 0; aop_s = 0; asrc_s = 0; rw_n = 0; mr_n = 0; mw_n = 0;
                    m2r_s = 0; rdst_s = 0; pre_bad = 0; hold_bad = 0;
                end else if (active) begin
                    cyc++;
                end
                if (active) begin
                    if (stage == 3'd2) begin
                        exec_n++;
                        aop_s  = int'(alu_op);
                        asrc_s = int'(ALU_Src);
                    end
                    if ((stage == 3'd0 || stage == 3'd1) && (alu_op != 2'b00 || ALU_Src))
                        pre_bad++;
                    if ((stage == 3'd3 || stage == 3'd4) && (int'(alu_op) != aop_s || int'(ALU_Src) != asrc_s))
                        hold_bad++;
                    if (reg_write) rw_n++;
                    if (mem_read) mr_n++;
                    if (mem_write) mw_n++;
                    if (reg_write && mem_to_reg) m2r_s = 1;
                    if (reg_write && reg_dst) rdst_s = 1;
                end
                if (pc_write) begin
                    if (!active || sb.size() == 0) begin
                        chk("unexpected_pc_write", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("latency op%0d", e.op), cyc, e.lat);
                        chk($sformatf("exec_cycles op%0d", e.op), exec_n, e.exec);
                        chk($sformatf("alu_op op%0d", e.op), aop_s, e.aop);
                        chk($sformatf("ALU_Src op%0d", e.op), asrc_s, e.asrc);
                        chk($sformatf("pc_src op%0d", e.op), int'(pc_src), e.psrc);
                        chk($sformatf("reg_write op%0d", e.op), rw_n, e.rw);
                        chk($sformatf("mem_read op%0d", e.op), mr_n, e.mr);
                        chk($sformatf("mem_write op%0d", e.op), mw_n, e.mw);
                        chk($sformatf("mem_to_reg op%0d", e.op), m2r_s, e.m2r);
                        chk($sformatf("reg_dst op%0d", e.op), rdst_s, e.rdst);
                        chk($sformatf("alu_idle op%0d", e.op), pre_bad, 0);
                        chk($sformatf("alu_hold op%0d", e.op), hold_bad, 0);
                        chk($sformatf("halted op%0d", e.op), int'(halted), 0);
                        chk($sformatf("instr_count op%0d", e.op), int'(instr_count), int'(exp_count));
                        exp_count = exp_count + 16'd1;
                    end
                    active = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        chk("global_timeout", 1, 0);
        finish_run();
    end

    // Driver
    initial begin
        int legal[7] = '{0, 8, 35, 43, 4, 5, 2};
        int op, fn, n;
        reset_n = 1'b0;
        enable  = 1'b1;
        opcode  = '0;
        funct   = '0;
        ZERO    = 1'b0;
        @(negedge clock);
        chk("reset_stage", int'(stage), 0);
        chk("reset_halted", int'(halted), 0);
        chk("reset_count", int'(instr_count), 0);
        chk("reset_ir_write", int'(ir_write), 0);
        chk("reset_pc_write", int'(pc_write), 0);
        step();
        reset_n = 1'b1;
        enable  = 1'b0;

        issue(0, 32, 0);
        issue(35, 0, 0);
        issue(43, 0, 0);
        issue(4, 0, 1);
        issue(5, 0, 1);
        issue(0, 26, 0);
        issue(0, 36, 0);
        issue(2, 0, 0);

        wait_fetch();
        enable = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("idle_stage", int'(stage), 0);
            chk("idle_ir_write", int'(ir_write), 0);
            step();
        end

        repeat (80) begin
            op = legal[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 24 : 26) : $urandom_range(0, 63);
            if ($urandom_range(0, 4) == 0) begin
                wait_fetch();
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            issue(op, fn, $urandom_range(0, 1));
        end

        // Abort an LW in WRITEBACK: nothing may retire and the count restarts.
        issue(35, 0, 0);
        n = 0;
        while (stage != 3'd4 && n < 20) begin
            step();
            n++;
        end
        chk("lw_reach_wb", int'(stage), 4);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        chk("abort_reg_write", int'(reg_write), 0);
        chk("abort_pc_write", int'(pc_write), 0);
        chk("abort_stage", int'(stage), 0);
        chk("abort_count", int'(instr_count), 0);
        step();
        reset_n = 1'b1;
        enable  = 1'b0;
        issue(0, 32, 0);

        wait_fetch();
        opcode = 6'h3F;
        enable = 1'b1;
        step();
        step();
        repeat (20) begin
            @(negedge clock);
            chk("halt_stage", int'(stage), 7);
            chk("halt_flag", int'(halted), 1);
            chk("halt_pc_write", int'(pc_write), 0);
            chk("halt_ir_write", int'(ir_write), 0);
            step();
            opcode = 6'($urandom);
        end
        reset_n = 1'b0;
        @(negedge clock);
        chk("unhalt_stage", int'(stage), 0);
        chk("unhalt_flag", int'(halted), 0);
        step();
        reset_n = 1'b1;
        enable  = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);
        finish_run();
    end

endmodule

// File: doc/alu_cycle_controller.md
Name: alu_cycle_controller

Overview:
- Multi-cycle sequencer for the ALU-centred MIPS datapath.
- Drives the 3-bit `stage` bus that the ALU and the other stage-gated units act on.
- Decodes the latched opcode/funct into `alu_op`, `ALU_Src` and the register-file, memory and PC strobes.
- Holds EXECUTE for multi-cycle MUL/DIV, resolves BEQ/BNE from `ZERO`, halts on an illegal opcode.

Parameters:
- MULDIV_CYCLES, 4, cycles spent in EXECUTE for funct 011000 (MUL) / 011010 (DIV); must be ≥ 1.
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  allow a new fetch; sampled only in FETCH.
- opcode  in  6  instruction[31:26]; valid while stage==0.
- funct  in  6  instruction[5:0]; valid while stage==0.
- ZERO  in  1  ALU zero flag; valid from the edge that leaves stage 2.
- stage  out  3  0=FETCH 1=DECODE 2=EXECUTE 3=MEMORY 4=WRITEBACK 7=HALT.
- alu_op  out  2  00 R-type, 11 ADDI/LW/SW, 01 BEQ/BNE, 10 unused.
- ALU_Src  out  1  1 selects sign_extend as ALU input B.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register-file write strobe.
- mem_read  out  1  data-memory read.
- mem_write  out  1  data-memory write.
- mem_to_reg  out  1  write-back source is memory.
- ir_write  out  1  instruction-register load.
- pc_write  out  1  PC update; one cycle per retired instruction.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
- halted  out  1  sticky illegal-opcode flag.
- instr_count  out  COUNT_W  retired-instruction count.

Behaviour:
- Registered state: `stage`, latched opcode/funct (op_q/fn_q), MUL/DIV cycle counter, `halted`, `instr_count`.
- Control outputs are combinational from (stage, op_q, fn_q, ZERO, enable) and are forced to 0 while reset_n=0.
- Reset (async): stage=0, op_q=fn_q=0, counter=0, halted=0, instr_count=0.
- FETCH (0): ir_write=enable. If enable=1, latch opcode/funct and go to DECODE; otherwise stay, all strobes 0.
- DECODE (1):
  - J (000010): pc_write=1, pc_src=10, go to FETCH.
  - R (000000), ADDI (001000), LW (100011), SW (101011), BEQ (000100), BNE (000101): go to EXECUTE; load the counter with MULDIV_CYCLES-1 if op R and fn_q is MUL/DIV, else 0.
  - Any other opcode: go to HALT, set halted=1.
- EXECUTE (2):
  - alu_op and ALU_Src driven per op_q: R gives 00/0; ADDI/LW/SW give 11/1; BEQ/BNE give 01/0.
  - If counter≠0: decrement it and stay.
  - Else: R/ADDI go to WRITEBACK; LW/SW/BEQ/BNE go to MEMORY.
- MEMORY (3):
  - LW: mem_read=1, go to WRITEBACK.
  - SW: mem_write=1, pc_write=1, pc_src=00, go to FETCH.
  - BEQ/BNE: pc_write=1. pc_src=01 if (BEQ&ZERO)|(BNE&!ZERO), else 00. Go to FETCH.
- WRITEBACK (4):
  - reg_write=1, pc_write=1, pc_src=00, go to FETCH.
  - reg_dst=1 for R only; mem_to_reg=1 for LW only.
- HALT (7): all strobes 0; stays until reset_n=0. enable is ignored.
- alu_op/ALU_Src hold their EXECUTE values through MEMORY/WRITEBACK and are 00/0 in FETCH/DECODE/HALT.
- instr_count increments by 1, wrapping modulo 2^COUNT_W, on every clock edge where pc_write=1.
- Latencies:
  - J: 2 cycles.
  - SW, BEQ, BNE: 4 cycles.
  - R, ADDI: 4 cycles; MUL/DIV 3+MULDIV_CYCLES.
  - LW: 5 cycles.
- Reset mid-instruction: immediate return to FETCH; no pc_write or reg_write is emitted for the aborted instruction; instr_count clears.
- Changes to opcode/funct outside FETCH have no effect.

Test Plan:
- Reset, enable=1, R ADD (op 000000, fn 100000) → stage 0,1,2,4,0; reg_write, reg_dst, pc_write high only in stage 4; instr_count=1.
- LW (100011) then SW (101011) → LW stages 0,1,2,3,4 with mem_read in 3 and mem_to_reg in 4, alu_op=11, ALU_Src=1; SW stages 0,1,2,3 with mem_write in 3; instr_count=2.
- BEQ with ZERO=1, then BNE with ZERO=1 → BEQ: pc_src=01 in stage 3. BNE: pc_src=00. pc_write=1 in stage 3 for both.
- DIV (fn 011010), MULDIV_CYCLES=4 → stage=2 for exactly 4 cycles, 7 cycles total; AND (fn 100100) holds stage=2 for 1 cycle.
- J (000010) → pc_src=10, pc_write in stage 1, back to FETCH after 2 cycles. Opcode 111111 → stage=7, halted=1, stays 20 cycles with enable=1; reset_n low clears to stage 0.
- enable=0 in FETCH for 5 cycles → stage stays 0, ir_write=0. reset_n pulsed low in WRITEBACK of LW → no reg_write, instr_count=0, stage=0.
